// File: rtl/whirlpool_pkg.sv
// Shared Whirlpool row-transform constants, GF(2^8) helpers and row FSM encoding.
package whirlpool_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ROW_BYTES = 8;
    localparam int unsigned ROW_W     = BYTE_W * ROW_BYTES;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned NIB_W     = 4;

    // Reduction polynomial x^8+x^4+x^3+x^2+1.
    localparam logic [8:0] GF_POLY = 9'h11D;

    // Mini-boxes, entry 0 first.
    localparam logic [0:15][NIB_W-1:0] E_BOX  = 64'h1B9CD6F3E874A250;
    localparam logic [0:15][NIB_W-1:0] EI_BOX = 64'hF0D7BE5A92C13486;
    localparam logic [0:15][NIB_W-1:0] R_BOX  = 64'h7CBDE49F638A2510;

    // Forward theta circulant and its inverse, coefficient 0 first.
    localparam logic [0:ROW_BYTES-1][BYTE_W-1:0] FWD_C = 64'h0101040108050209;
    localparam logic [0:ROW_BYTES-1][BYTE_W-1:0] INV_D = 64'h04AF0EA4C2C2CB3E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_THETA = 2'd1,
        ST_SBOX  = 2'd2,
        ST_DONE  = 2'd3
    } row_state_t;

    // Row as bytes; byte 0 is the most significant byte.
    typedef logic [0:ROW_BYTES-1][BYTE_W-1:0] row_bytes_t;

    function automatic logic [NIB_W-1:0] e_box(input logic [NIB_W-1:0] x);
        return E_BOX[x];
    endfunction

    function automatic logic [NIB_W-1:0] ei_box(input logic [NIB_W-1:0] x);
        return EI_BOX[x];
    endfunction

    function automatic logic [NIB_W-1:0] r_box(input logic [NIB_W-1:0] x);
        return R_BOX[x];
    endfunction

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
        return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_POLY[BYTE_W-1:0] : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            if (b[IDX_W'(i)]) acc ^= sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// Combinational inverse Whirlpool S-box built from the E/EI/R mini-boxes.
module inv_s_box
    import whirlpool_pkg::*;
(
    input  logic [7:0] y,
    output logic [7:0] x_c
);

    logic [NIB_W-1:0] a;
    logic [NIB_W-1:0] b;
    logic [NIB_W-1:0] r;

    // Undo the outer mini-boxes, then the shared R layer.
    always_comb begin
        a   = ei_box(y[7:4]);
        b   = e_box(y[3:0]);
        r   = r_box(a ^ b);
        x_c = {ei_box(a ^ r), e_box(b ^ r)};
    end

endmodule

// File: rtl/inv_process_row.sv
// Byte-serial inverse of the Whirlpool row transform: one theta cycle, then eight S-box cycles.
module inv_process_row
    import whirlpool_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_row,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_row
);

    row_state_t       state_q;
    row_state_t       state_d;
    logic [IDX_W-1:0] k_q;
    row_bytes_t       work_q;
    row_bytes_t       theta_c;
    logic [7:0]       sbox_x_c;
    logic             load_c;
    logic             theta_en_c;
    logic             sbox_en_c;

    inv_s_box u_inv_s_box (
        .y   (work_q[k_q]),
        .x_c (sbox_x_c)
    );

    // Inverse theta: each output byte is a GF(2^8) dot product with the rotated row.
    always_comb begin
        theta_c = '0;
        for (int unsigned i = 0; i < ROW_BYTES; i++) begin
            for (int unsigned j = 0; j < ROW_BYTES; j++) begin
                theta_c[IDX_W'(i)] ^= gf_mul(INV_D[IDX_W'(j)], work_q[IDX_W'(i + j)]);
            end
        end
    end

    // Next-state and datapath enables.
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        theta_en_c = 1'b0;
        sbox_en_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    state_d = ST_THETA;
                end
            end
            ST_THETA: begin
                theta_en_c = 1'b1;
                state_d    = ST_SBOX;
            end
            ST_SBOX: begin
                sbox_en_c = 1'b1;
                if (k_q == IDX_W'(ROW_BYTES - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, byte counter, working row and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            work_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            if (load_c) begin
                work_q <= in_row;
            end else if (theta_en_c) begin
                work_q <= theta_c;
                k_q    <= '0;
            end else if (sbox_en_c) begin
                work_q[k_q] <= sbox_x_c;
                k_q         <= k_q + 3'd1;
            end
        end
    end

    assign out_row = work_q;

endmodule

// File: tb/tb_inv_process_row.sv
// Self-checking bench for inv_process_row: forward-transform model feeds rows, scoreboard checks recovery.
module tb_inv_process_row;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_row = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_row;
    logic [7:0]  sb_y = '0;
    logic [7:0]  sb_x;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [63:0] cur_exp = '0;
    logic [63:0] exp_q[$];
    int          acc_q[$];
    logic        prev_ov = 1'b0;

    inv_process_row dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row)
    );

    inv_s_box u_sbox_chk (
        .y   (sb_y),
        .x_c (sb_x)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference forward transform, built independently of the RTL tables.
    function automatic logic [3:0] m_e(input logic [3:0] x);
        logic [0:15][3:0] t;
        t = 64'h1B9CD6F3E874A250;
        return t[x];
    endfunction

    function automatic logic [3:0] m_r(input logic [3:0] x);
        logic [0:15][3:0] t;
        t = 64'h7CBDE49F638A2510;
        return t[x];
    endfunction

    function automatic logic [3:0] m_ei(input logic [3:0] v);
        for (int i = 0; i < 16; i++) begin
            if (m_e(4'(i)) == v) return 4'(i);
        end
        return 4'h0;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [3:0] u, l, r;
        u = m_e(x[7:4]);
        l = m_ei(x[3:0]);
        r = m_r(u ^ l);
        return {m_e(u ^ r), m_ei(l ^ r)};
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, s;
        p = '0;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p ^= s;
            s = s[7] ? ({s[6:0], 1'b0} ^ 8'h1D) : {s[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [63:0] m_fwd(input logic [63:0] x);
        logic [0:7][7:0] xb, sb, yb, c;
        xb = x;
        c  = 64'h0101040108050209;
        for (int i = 0; i < 8; i++) sb[3'(i)] = m_sbox(xb[3'(i)]);
        for (int i = 0; i < 8; i++) begin
            yb[3'(i)] = '0;
            for (int j = 0; j < 8; j++) yb[3'(i)] ^= m_mul(c[3'(j)], sb[3'(i + j)]);
        end
        return yb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: record accepts, check latency on out_valid rise and data on transfer.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_q.push_back(cyc);
            end
            if (out_valid && !prev_ov) begin
                chk("out_expected", 64'(acc_q.size() != 0), 64'd1);
                if (acc_q.size() != 0) chk("latency", 64'(cyc - acc_q[0]), 64'd10);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("row", out_row, exp_q.pop_front());
                acc_q.delete(0);
            end
            prev_ov = out_valid;
        end
    end

    // Present one row and hold it until accepted; called just after a rising edge.
    task automatic send(input logic [63:0] row, input logic [63:0] exp, output int acc_cyc);
        int n;
        in_row   = row;
        cur_exp  = exp;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        chk("accept_ready", 64'(in_ready), 64'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          a, prev, n;
        logic [63:0] x;
        logic [0:7][7:0] xb;

        for (int v = 0; v < 256; v++) begin
            sb_y = m_sbox(8'(v));
            #1;
            chk("inv_sbox", 64'(sb_x), 64'(v));
        end
        sb_y = 8'h18;
        #1;
        chk("inv_sbox_18", 64'(sb_x), 64'h00);
        sb_y = 8'h23;
        #1;
        chk("inv_sbox_23", 64'(sb_x), 64'h01);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_row", out_row, 64'd0);
        @(posedge clk);
        #1;

        send(64'h2828282828282828, 64'd0, a);
        drain();

        prev = 0;
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 8; b++) xb[3'(b)] = 8'(r * 8 + b);
            x = xb;
            send(m_fwd(x), x, a);
            if (r > 0) chk("throughput", 64'(a - prev), 64'd11);
            prev = a;
        end
        drain();

        for (int r = 0; r < 2000; r++) begin
            x = {$urandom, $urandom};
            send(m_fwd(x), x, a);
        end
        drain();

        out_ready = 1'b0;
        x = {$urandom, $urandom};
        send(m_fwd(x), x, a);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        chk("bp_valid_rise", 64'(out_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0);
            in_row   = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_row", out_row, x);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle", 64'(in_ready), 64'd1);
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        x = {$urandom, $urandom};
        send(m_fwd(x), x, a);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_row", out_row, 64'd0);
        repeat (15) @(negedge clk);
        chk("mid_rst_no_output", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        x = {$urandom, $urandom};
        send(m_fwd(x), x, a);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
